// File: rtl/shreg_universal.sv
// rtl/shreg_universal.sv - parametrised universal shift/rotate register with auto shift-by-N sequencer
// Per-edge ops apply MODE directly in IDLE; RUN replays a latched shift mode for CNT enabled edges.
module shreg_universal #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CE,
   input  logic [2:0]       MODE,
   input  logic [WIDTH-1:0] Din,
   input  logic             SIL,
   input  logic             SIR,
   input  logic             START,
   input  logic [CNT_W-1:0] CNT,
   output logic [WIDTH-1:0] Dout,
   output logic             SOL,
   output logic             SOR,
   output logic             BUSY,
   output logic             DONE
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic [2:0] M_HOLD  = 3'b000;
   localparam logic [2:0] M_LOAD  = 3'b001;
   localparam logic [2:0] M_SHL   = 3'b010;
   localparam logic [2:0] M_SHR   = 3'b011;
   localparam logic [2:0] M_ROTL  = 3'b100;
   localparam logic [2:0] M_ROTR  = 3'b101;
   localparam logic [2:0] M_ASHR  = 3'b110;
   localparam logic [2:0] M_CLEAR = 3'b111;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic [2:0]         mode_q, mode_d;
   logic               done_q, done_d;

   function automatic logic [WIDTH-1:0] apply_op(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] cur,
      input logic [WIDTH-1:0] din,
      input logic             sil,
      input logic             sir
   );
      logic [WIDTH-1:0] res;
      res = cur;
      case (op)
         M_HOLD:  res = cur;
         M_LOAD:  res = din;
         M_SHL:   res = {cur[WIDTH-2:0], sil};
         M_SHR:   res = {sir, cur[WIDTH-1:1]};
         M_ROTL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
         M_ROTR:  res = {cur[0], cur[WIDTH-1:1]};
         M_ASHR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
         M_CLEAR: res = '0;
         default: res = cur;
      endcase
      return res;
   endfunction

   logic is_shift_mode;
   assign is_shift_mode = (MODE >= M_SHL) && (MODE <= M_ASHR);

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      mode_d  = mode_q;
      done_d  = done_q;
      if (CE) begin
         done_d = 1'b0;
         case (state_q)
            S_IDLE: begin
               if (START && is_shift_mode) begin
                  if (CNT != '0) begin
                     mode_d  = MODE;
                     rem_d   = CNT;
                     state_d = S_RUN;
                  end else begin
                     done_d = 1'b1;
                  end
               end else begin
                  data_d = apply_op(MODE, data_q, Din, SIL, SIR);
               end
            end
            S_RUN: begin
               // Serial inputs are sampled live each edge; Din is irrelevant for shift modes.
               data_d = apply_op(mode_q, data_q, Din, SIL, SIR);
               rem_d  = rem_q - 1'b1;
               if (rem_q == CNT_W'(1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         rem_q   <= '0;
         mode_q  <= M_HOLD;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

   assign Dout = data_q;
   assign SOL  = data_q[WIDTH-1];
   assign SOR  = data_q[0];
   assign BUSY = (state_q == S_RUN);
   assign DONE = done_q;

endmodule

// File: tb/tb_shreg_universal.sv
// tb/tb_shreg_universal.sv - scoreboard bench for shreg_universal
// Stimulus pushes per-edge expectations; a monitor pops and compares after each edge.
module tb_shreg_universal;

   logic       CLK = 1'b0;
   logic       RST, CE, SIL, SIR, START;
   logic [2:0] MODE;
   logic [7:0] Din;
   logic [3:0] CNT;
   logic [7:0] Dout;
   logic       SOL, SOR, BUSY, DONE;

   shreg_universal #(.WIDTH(8), .CNT_W(4)) dut (
      .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .Din(Din), .SIL(SIL), .SIR(SIR),
      .START(START), .CNT(CNT), .Dout(Dout), .SOL(SOL), .SOR(SOR), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] dout;
      logic       busy;
      logic       done;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, req);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, ".dout"}, Dout, e.dout);
            check({e.name, ".busy"}, {7'd0, BUSY}, {7'd0, e.busy});
            check({e.name, ".done"}, {7'd0, DONE}, {7'd0, e.done});
            check({e.name, ".sol"},  {7'd0, SOL},  {7'd0, e.dout[7]});
            check({e.name, ".sor"},  {7'd0, SOR},  {7'd0, e.dout[0]});
         end
      end
   end

   // Drive one edge's inputs and queue the state expected right after that edge.
   task automatic cyc(input logic ce, input logic rst, input logic [2:0] mode,
                      input logic [7:0] din, input logic sil, input logic sir,
                      input logic start, input logic [3:0] cnt,
                      input logic [7:0] ed, input logic eb, input logic edn, input string nm);
      exp_t e;
      @(negedge CLK);
      #1;
      CE = ce; RST = rst; MODE = mode; Din = din; SIL = sil; SIR = sir; START = start; CNT = cnt;
      e.dout = ed; e.busy = eb; e.done = edn; e.name = nm;
      exp_q.push_back(e);
   endtask

   task automatic op(input logic [2:0] mode, input logic [7:0] din, input logic sil,
                     input logic sir, input logic [7:0] ed, input string nm);
      cyc(1, 0, mode, din, sil, sir, 0, 4'd0, ed, 0, 0, nm);
   endtask

   initial begin
      CE = 0; RST = 0; MODE = 0; Din = 0; SIL = 0; SIR = 0; START = 0; CNT = 0;

      // reset, then reset priority over a load with CE=1
      cyc(1, 1, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0, "rst0");
      op(3'b001, 8'hA5, 0, 0, 8'hA5, "loadA5");
      cyc(1, 1, 3'b001, 8'hFF, 0, 0, 1, 4'd3, 8'h00, 0, 0, "rst_prio");
      op(3'b001, 8'h3C, 0, 0, 8'h3C, "load3C");

      // single steps
      op(3'b001, 8'h81, 0, 0, 8'h81, "load81");
      op(3'b100, 8'h00, 0, 0, 8'h03, "rotl");
      op(3'b101, 8'h00, 0, 0, 8'h81, "rotr");
      op(3'b110, 8'h00, 0, 0, 8'hC0, "ashr");
      op(3'b011, 8'h00, 1, 0, 8'h60, "shr_sir0");
      op(3'b010, 8'h00, 1, 0, 8'hC1, "shl_sil1");
      op(3'b000, 8'hFF, 0, 0, 8'hC1, "hold");
      cyc(0, 0, 3'b001, 8'hFF, 0, 0, 0, 4'd0, 8'hC1, 0, 0, "ce0_load");
      op(3'b001, 8'h90, 0, 0, 8'h90, "load90");
      op(3'b110, 8'h00, 0, 0, 8'hC8, "ashr_neg");
      op(3'b011, 8'h00, 0, 1, 8'hE4, "shr_sir1");

      // auto rotl by 3, START during RUN ignored
      op(3'b001, 8'h01, 0, 0, 8'h01, "load01");
      cyc(1, 0, 3'b100, 8'h00, 0, 0, 1, 4'd3, 8'h01, 1, 0, "rotl3_acc");
      cyc(1, 0, 3'b001, 8'hFF, 0, 0, 1, 4'd5, 8'h02, 1, 0, "rotl3_r1");
      cyc(1, 0, 3'b111, 8'hFF, 0, 0, 1, 4'd5, 8'h04, 1, 0, "rotl3_r2");
      cyc(1, 0, 3'b010, 8'hFF, 0, 0, 1, 4'd2, 8'h08, 0, 1, "rotl3_fin");
      op(3'b000, 8'h00, 0, 0, 8'h08, "rotl3_after");

      // auto shl by 5 with a 4-cycle CE gap, then DONE stretch
      op(3'b001, 8'h01, 0, 0, 8'h01, "load01b");
      cyc(1, 0, 3'b010, 8'h00, 0, 0, 1, 4'd5, 8'h01, 1, 0, "shl5_acc");
      cyc(1, 0, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h02, 1, 0, "shl5_r1");
      cyc(1, 0, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h04, 1, 0, "shl5_r2");
      for (int i = 0; i < 4; i++)
         cyc(0, 0, 3'b001, 8'hFF, 1, 1, 1, 4'd1, 8'h04, 1, 0, "shl5_gap");
      cyc(1, 0, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h08, 1, 0, "shl5_r3");
      cyc(1, 0, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h10, 1, 0, "shl5_r4");
      cyc(1, 0, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h20, 0, 1, "shl5_fin");
      cyc(0, 0, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h20, 0, 1, "done_str1");
      cyc(0, 0, 3'b001, 8'hFF, 0, 0, 0, 4'd0, 8'h20, 0, 1, "done_str2");
      op(3'b000, 8'h00, 0, 0, 8'h20, "done_clr");

      // CNT=0 and START with a non-shift mode
      op(3'b001, 8'h5A, 0, 0, 8'h5A, "load5A");
      cyc(1, 0, 3'b010, 8'h00, 1, 1, 1, 4'd0, 8'h5A, 0, 1, "cnt0");
      op(3'b000, 8'h00, 0, 0, 8'h5A, "cnt0_after");
      cyc(1, 0, 3'b111, 8'h00, 0, 0, 1, 4'd4, 8'h00, 0, 0, "start_clear");
      op(3'b000, 8'h00, 0, 0, 8'h00, "clear_after");

      // reset mid-run, then a fresh run with live SIR
      op(3'b001, 8'h01, 0, 0, 8'h01, "load01c");
      cyc(1, 0, 3'b010, 8'h00, 1, 0, 1, 4'd6, 8'h01, 1, 0, "shl6_acc");
      cyc(1, 0, 3'b000, 8'h00, 1, 0, 0, 4'd0, 8'h03, 1, 0, "shl6_r1");
      cyc(1, 1, 3'b000, 8'h00, 1, 0, 0, 4'd0, 8'h00, 0, 0, "shl6_rst");
      cyc(1, 0, 3'b011, 8'h00, 0, 1, 1, 4'd2, 8'h00, 1, 0, "shr2_acc");
      cyc(1, 0, 3'b000, 8'h00, 0, 1, 0, 4'd0, 8'h80, 1, 0, "shr2_r1");
      cyc(1, 0, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h40, 0, 1, "shr2_fin");
      op(3'b000, 8'h00, 0, 0, 8'h40, "shr2_after");

      // max count rotate wraps modulo WIDTH
      op(3'b001, 8'h01, 0, 0, 8'h01, "load01d");
      cyc(1, 0, 3'b100, 8'h00, 0, 0, 1, 4'd15, 8'h01, 1, 0, "rotl15_acc");
      for (int k = 1; k <= 15; k++)
         cyc(1, 0, 3'b000, 8'h00, 0, 0, 0, 4'd0, 8'h01 << (k % 8), (k < 15), (k == 15), "rotl15_run");
      op(3'b000, 8'h00, 0, 0, 8'h80, "rotl15_after");

      repeat (4) @(posedge CLK);
      #3;
      n_total++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
